anita3_scaler_readout_ctrl: RTL
===============================

# anita3_scaler_readout_ctrl

Sequences the once-per-second readout of the TURF scaler bank: deadtime, trigger and occupancy scalers latched on the 33 MHz PPS. On each accepted PPS it waits for the scalers to settle, snapshots all channels in one cycle, and streams a header beat plus one beat per channel to the readout/housekeeping path over a valid/ready handshake. PPS overruns are flagged, not queued. It sits between the scaler datapaths and the register/readout interface, in the clk33 domain.

## Interface
- NSCALERS, 8, number of scaler channels (1..255)
- WIDTH, 16, scaler and stream word width (>= 16)
- SETTLE, 2, clk33 cycles from PPS to snapshot (1..15); covers the one-cycle scaler latch after pps_clk33_i

- clk33_i  in  1  33 MHz clock; all logic on its rising edge
- rst_n_i  in  1  asynchronous active-low reset
- pps_clk33_i  in  1  single-cycle PPS pulse, already in the clk33 domain
- enable_i  in  1  readout enable; gates acceptance of new PPS only
- scaler_i  in  NSCALERS*WIDTH  scaler bank; channel k is bits [k*WIDTH +: WIDTH]
- data_o  out  WIDTH  stream data, registered
- chan_o  out  8  beat index: 0 = header, k+1 = channel k
- valid_o  out  1  stream valid
- ready_i  in  1  stream ready
- last_o  out  1  final beat of frame
- busy_o  out  1  state != IDLE
- overrun_o  out  1  sticky: a PPS arrived while busy
- clear_overrun_i  in  1  clears overrun_o
- seq_o  out  8  frame sequence number, incremented at each snapshot

## Operation
- States: IDLE, SETTLE, SEND.
- IDLE: pps_clk33_i && enable_i -> SETTLE, settle counter loaded with SETTLE-1. Otherwise stay in IDLE.
- SETTLE: decrement. At counter==0 the block snapshots all of scaler_i into internal registers, increments seq (mod 256), sets beat index 0, asserts valid_o, and moves to SEND.
- SEND: a beat transfers when valid_o && ready_i.
  - Header beat: data_o = {header constant 8'hA5, seq_o}, zero-extended in the MSBs when WIDTH > 16.
  - Beat k+1: data_o = snapshot[k].
  - last_o is high only with chan_o == NSCALERS.
  - After the transfer of the last beat, valid_o deasserts and the state returns to IDLE.
- data_o, chan_o and last_o are stable while valid_o && !ready_i. valid_o is never withdrawn before a transfer.
- Overrun: pps_clk33_i in SETTLE or SEND sets overrun_o. The pulse is dropped, and the current frame completes unchanged.
- Exception: a PPS in the same cycle as the final-beat transfer is accepted, goes to SETTLE, and is not an overrun.
- Setting the overrun has priority over clear_overrun_i in the same cycle.
- enable_i deasserted mid-frame has no effect on that frame.
- Reset (any state, asynchronous): state IDLE; valid_o, last_o, busy_o, overrun_o = 0; data_o, chan_o, seq_o = 0; snapshot cleared. An in-flight frame is abandoned, with no partial last_o.

## Timing
- PPS high at edge T (IDLE) -> busy_o high after T. Snapshot at edge T+SETTLE; valid_o and header presented after T+SETTLE.
- With ready_i held high: one beat per cycle, NSCALERS+1 beats. last_o transfers at edge T+SETTLE+NSCALERS+1, and busy_o falls after that edge.
- Minimum PPS spacing without overrun: SETTLE+NSCALERS+1 cycles. At 1 Hz this limit is never reached unless ready_i stalls for about 1 s.
- Scaler values captured are those present on scaler_i in the cycle before edge T+SETTLE. Later changes do not affect the frame.

## Structure
- Shared package anita3_scaler_pkg holds:
  - state enum (IDLE/SETTLE/SEND)
  - ANITA3_SCALER_HDR = 8'hA5
  - default NSCALERS/WIDTH constants, shared with the scaler datapath modules
- Sub-module anita3_scaler_snapshot: NSCALERS x WIDTH register bank with a load strobe and a mux read by index. The controller FSM, counters and handshake remain in the top module.

## Test plan
- Reset, then PPS with enable_i=1, ready_i=1, SETTLE=2, channels = 16'h1000+k:
  - valid_o rises 2 cycles after PPS.
  - Header 16'hA501, then 16'h1000..16'h1007 on chan_o 1..8; last_o on chan 8.
  - busy_o clears the next cycle.
- Random ready_i stalls: outputs stay frozen during stalls, all 9 beats arrive in order, and none are dropped or duplicated.
- PPS at chan_o=3 of the frame: overrun_o=1, the frame completes unchanged, and no new frame starts. Then clear_overrun_i -> overrun_o=0. Clear and a new overrun in the same cycle -> overrun_o=1.
- PPS coincident with the last-beat transfer: overrun_o stays 0, and a new frame with seq 0x02 follows SETTLE cycles later.
- enable_i=0 at PPS: no frame, seq unchanged. enable_i dropped mid-frame: the frame completes.
- rst_n_i asserted mid-SEND: all outputs zero immediately, with no last_o. The next PPS produces a header with seq 0x01.

Source files
------------

// File: rtl/anita3_scaler_pkg.sv
// Shared definitions for the ANITA-3 TURF scaler readout path.
// Holds the default bank geometry, the frame header tag and the readout FSM state type.
package anita3_scaler_pkg;

    localparam int ANITA3_NSCALERS_DEF = 8;
    localparam int ANITA3_WIDTH_DEF    = 16;
    localparam int ANITA3_SETTLE_DEF   = 2;

    localparam logic [7:0] ANITA3_SCALER_HDR = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SEND   = 2'd2
    } anita3_scaler_state_e;

    // 16-bit header word: tag in the upper byte, frame sequence number in the lower byte
    function automatic logic [15:0] anita3_hdr_beat(input logic [7:0] seq);
        return {ANITA3_SCALER_HDR, seq};
    endfunction

endpackage

// File: rtl/anita3_scaler_snapshot.sv
// NSCALERS x WIDTH snapshot register bank: all channels captured on one load strobe,
// read back one channel at a time through an index mux.
module anita3_scaler_snapshot
    import anita3_scaler_pkg::*;
#(
    parameter int NSCALERS = ANITA3_NSCALERS_DEF,
    parameter int WIDTH    = ANITA3_WIDTH_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      load_i,
    input  logic [NSCALERS*WIDTH-1:0] scaler_i,
    input  logic [7:0]                rd_idx_i,
    output logic [WIDTH-1:0]          rd_data_o
);

    logic [NSCALERS*WIDTH-1:0] snap_flat;

    generate
        for (genvar gi = 0; gi < NSCALERS; gi++) begin : g_chan
            logic [WIDTH-1:0] word_q;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    word_q <= '0;
                end else if (load_i) begin
                    word_q <= scaler_i[gi*WIDTH +: WIDTH];
                end
            end

            assign snap_flat[gi*WIDTH +: WIDTH] = word_q;
        end
    endgenerate

    // Out-of-range indices read as zero
    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < NSCALERS; k++) begin
            if (rd_idx_i == 8'(k)) begin
                rd_data_o = snap_flat[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/anita3_scaler_readout_ctrl.sv
// Once-per-second scaler readout sequencer: on an accepted PPS it waits for the scalers
// to settle, snapshots the bank and streams a header plus one beat per channel.
module anita3_scaler_readout_ctrl
    import anita3_scaler_pkg::*;
#(
    parameter int NSCALERS = ANITA3_NSCALERS_DEF,
    parameter int WIDTH    = ANITA3_WIDTH_DEF,
    parameter int SETTLE   = ANITA3_SETTLE_DEF
) (
    input  logic                      clk33_i,
    input  logic                      rst_n_i,
    input  logic                      pps_clk33_i,
    input  logic                      enable_i,
    input  logic [NSCALERS*WIDTH-1:0] scaler_i,
    output logic [WIDTH-1:0]          data_o,
    output logic [7:0]                chan_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      last_o,
    output logic                      busy_o,
    output logic                      overrun_o,
    input  logic                      clear_overrun_i,
    output logic [7:0]                seq_o
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [7:0] LAST_CHAN   = 8'(NSCALERS);

    anita3_scaler_state_e state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       seq_q, seq_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [7:0]       chan_q, chan_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             overrun_q, overrun_d;

    logic             snap_load;
    logic [WIDTH-1:0] snap_rd_data;
    logic             xfer;
    logic             final_xfer;
    logic             pps_accept;

    anita3_scaler_snapshot #(
        .NSCALERS (NSCALERS),
        .WIDTH    (WIDTH)
    ) u_snapshot (
        .clk_i     (clk33_i),
        .rst_n_i   (rst_n_i),
        .load_i    (snap_load),
        .scaler_i  (scaler_i),
        .rd_idx_i  (chan_q),
        .rd_data_o (snap_rd_data)
    );

    assign xfer       = (state_q == ST_SEND) && valid_q && ready_i;
    assign final_xfer = xfer && last_q;
    assign pps_accept = pps_clk33_i && enable_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seq_d     = seq_q;
        data_d    = data_q;
        chan_d    = chan_q;
        valid_d   = valid_q;
        last_d    = last_q;
        overrun_d = overrun_q;
        snap_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pps_accept) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    snap_load = 1'b1;
                    seq_d     = seq_q + 8'd1;
                    data_d    = WIDTH'(anita3_hdr_beat(seq_q + 8'd1));
                    chan_d    = 8'd0;
                    valid_d   = 1'b1;
                    last_d    = 1'b0;
                    state_d   = ST_SEND;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_SEND: begin
                if (xfer) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        // A PPS landing on the final transfer starts the next frame directly
                        if (pps_accept) begin
                            state_d = ST_SETTLE;
                            cnt_d   = SETTLE_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        // Beat chan_q+1 carries snapshot channel chan_q
                        chan_d = chan_q + 8'd1;
                        data_d = snap_rd_data;
                        last_d = ((chan_q + 8'd1) == LAST_CHAN);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase

        if (pps_clk33_i && (state_q != ST_IDLE) && !final_xfer) begin
            overrun_d = 1'b1;
        end else if (clear_overrun_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            seq_q     <= '0;
            data_q    <= '0;
            chan_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            seq_q     <= seq_d;
            data_q    <= data_d;
            chan_q    <= chan_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign chan_o    = chan_q;
    assign valid_o   = valid_q;
    assign last_o    = last_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign overrun_o = overrun_q;
    assign seq_o     = seq_q;

endmodule
